// File: rtl/flush_drain_fifo.sv
// rtl/flush_drain_fifo.sv - FWFT circular FIFO with flush-and-drain handshake
module flush_drain_fifo #(
    parameter  int DATA_WIDTH = 32,
    parameter  int DEPTH      = 8,
    localparam int CW         = $clog2(DEPTH) + 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  flush_req,
    output logic                  flush_busy,
    output logic                  flush_done,
    output logic [CW-1:0]         flushed_count,
    output logic [CW-1:0]         level
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FLUSH = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [CW-1:0] LEVEL_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] COUNT_MAX  = {CW{1'b1}};

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] level_q, level_d;
    logic [CW-1:0] flushed_count_q, flushed_count_d;

    logic push;
    logic pop;

    // Input is only open in IDLE; a flush request in the same cycle wins over the beat.
    assign in_ready  = !reset && (state_q == ST_IDLE) && !flush_req && (level_q != LEVEL_FULL);
    assign out_valid = !reset && (level_q != '0);
    assign out_data  = mem[rd_ptr_q];

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    assign flush_busy    = (state_q != ST_IDLE);
    assign flush_done    = (state_q == ST_DONE);
    assign flushed_count = flushed_count_q;
    assign level         = level_q;

    // Storage array; contents are intentionally left unreset.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr_q] <= in_data;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of two.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        level_d  = level_q;
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   level_d = level_q + CW'(1);
            2'b01:   level_d = level_q - CW'(1);
            default: level_d = level_q;
        endcase
    end

    // Flush sequencer: drain to empty, then a single DONE cycle before reopening.
    always_comb begin
        state_d         = state_q;
        flushed_count_d = flushed_count_q;
        case (state_q)
            ST_IDLE: begin
                if (flush_req) begin
                    state_d         = ST_FLUSH;
                    flushed_count_d = '0;
                end
            end
            ST_FLUSH: begin
                if (pop && (flushed_count_q != COUNT_MAX)) begin
                    flushed_count_d = flushed_count_q + CW'(1);
                end
                // Uses post-pop occupancy so the last pop and the exit share an edge.
                if (level_d == '0) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset; a mid-flush reset abandons the flush silently.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            rd_ptr_q        <= '0;
            wr_ptr_q        <= '0;
            level_q         <= '0;
            flushed_count_q <= '0;
        end else begin
            state_q         <= state_d;
            rd_ptr_q        <= rd_ptr_d;
            wr_ptr_q        <= wr_ptr_d;
            level_q         <= level_d;
            flushed_count_q <= flushed_count_d;
        end
    end

endmodule

// File: tb/tb_flush_drain_fifo.sv
// tb/tb_flush_drain_fifo.sv - self-checking bench for flush_drain_fifo
module tb_flush_drain_fifo;

    localparam int DW    = 32;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int CMAX  = (1 << CW) - 1;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic          flush_req = 1'b0;
    logic          flush_busy;
    logic          flush_done;
    logic [CW-1:0] flushed_count;
    logic [CW-1:0] level;

    int checks = 0;
    int errors = 0;

    flush_drain_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .flush_req(flush_req), .flush_busy(flush_busy), .flush_done(flush_done),
        .flushed_count(flushed_count), .level(level)
    );

    always #5 clock = ~clock;

    // Reference model: queue of pending beats plus a flush phase (0 idle, 1 draining, 2 done).
    logic [DW-1:0] mq[$];
    int mphase = 0;
    int mcount = 0;

    function automatic bit m_in_ready();
        return !reset && mphase == 0 && !flush_req && mq.size() < DEPTH;
    endfunction

    function automatic bit m_out_valid();
        return !reset && mq.size() != 0;
    endfunction

    task automatic set_in(input bit rst, input bit iv, input logic [DW-1:0] id, input bit ordy, input bit freq);
        reset = rst; in_valid = iv; in_data = id; out_ready = ordy; flush_req = freq;
        #1;
    endtask

    task automatic tick();
        bit pop, push;
        if (reset) begin
            mq.delete(); mphase = 0; mcount = 0;
        end else begin
            pop  = m_out_valid() && out_ready;
            push = in_valid && m_in_ready();
            if (pop) void'(mq.pop_front());
            if (push) mq.push_back(in_data);
            case (mphase)
                0: if (flush_req) begin mphase = 1; mcount = 0; end
                1: begin
                    if (pop && mcount < CMAX) mcount++;
                    if (mq.size() == 0) mphase = 2;
                end
                default: mphase = 0;
            endcase
        end
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic drain_all();
        int n = 0;
        set_in(0, 0, '0, 1, 0);
        while (out_valid && n < 40) begin tick(); set_in(0, 0, '0, 1, 0); n++; end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_timeout: out_valid=%b expected 0", out_valid); end
    endtask

    task automatic test_reset();
        @(negedge clock);
        set_in(1, 1, 32'h1, 1, 0);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b expected 0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
        tick(); tick();
        set_in(0, 0, '0, 0, 0);
        checks++; if (level !== '0) begin errors++; $display("FAIL rst_level: got %0d expected 0", level); end
        checks++; if (flush_busy !== 1'b0 || flush_done !== 1'b0) begin errors++; $display("FAIL rst_flags: busy=%b done=%b expected 0 0", flush_busy, flush_done); end
        checks++; if (flushed_count !== '0) begin errors++; $display("FAIL rst_count: got %0d expected 0", flushed_count); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_after: got %b expected 1", in_ready); end
    endtask

    task automatic test_stream();
        for (int i = 0; i < 5; i++) begin
            set_in(0, 1, 32'hA0 + i, 1, 0);
            if (i > 0) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== 32'hA0 + i - 1) begin errors++; $display("FAIL stream_data%0d: got %b/%0h expected 1/%0h", i, out_valid, out_data, 32'hA0 + i - 1); end
            end
            checks++; if (level > 1) begin errors++; $display("FAIL stream_level%0d: got %0d expected <=1", i, level); end
            tick();
        end
        set_in(0, 0, '0, 1, 0);
        checks++; if (out_data !== 32'hA4) begin errors++; $display("FAIL stream_last: got %0h expected a4", out_data); end
        tick();
        set_in(0, 0, '0, 0, 0);
        checks++; if (level !== '0) begin errors++; $display("FAIL stream_empty: got %0d expected 0", level); end
    endtask

    task automatic test_fill_wrap();
        int sent = 0;
        int nexp = 100;
        for (int c = 0; c < 10; c++) begin
            set_in(0, 1, 100 + sent, 0, 0);
            if (in_ready) sent++;
            tick();
        end
        set_in(0, 1, 100 + sent, 0, 0);
        checks++; if (sent != 8) begin errors++; $display("FAIL fill_accepts: got %0d expected 8", sent); end
        checks++; if (level !== CW'(8)) begin errors++; $display("FAIL fill_level: got %0d expected 8", level); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_ready: got %b expected 0", in_ready); end
        for (int c = 0; c < 40 && nexp < 110; c++) begin
            set_in(0, sent < 10, 100 + sent, 1, 0);
            if (out_valid) begin
                checks++;
                if (out_data !== DW'(nexp)) begin errors++; $display("FAIL wrap_order: got %0d expected %0d", out_data, nexp); end
                nexp++;
            end
            if (in_ready && sent < 10) sent++;
            tick();
        end
        set_in(0, 0, '0, 0, 0);
        checks++; if (nexp != 110 || sent != 10) begin errors++; $display("FAIL wrap_total: popped %0d sent %0d expected 110 10", nexp, sent); end
        checks++; if (level !== '0) begin errors++; $display("FAIL wrap_level: got %0d expected 0", level); end
    endtask

    task automatic test_flush_basic();
        int pops = 0;
        bit seen = 0;
        for (int i = 0; i < 5; i++) begin set_in(0, 1, 200 + i, 0, 0); tick(); end
        set_in(0, 1, 32'hBAD, 0, 1);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_refuse: got %b expected 0", in_ready); end
        tick();
        for (int c = 0; c < 20 && !seen; c++) begin
            set_in(0, 1, 32'hBAD, 1, 0);
            if (flush_done) begin
                seen = 1;
                checks++; if (level !== '0) begin errors++; $display("FAIL flush_level: got %0d expected 0", level); end
                checks++; if (flushed_count !== CW'(5)) begin errors++; $display("FAIL flush_count: got %0d expected 5", flushed_count); end
                checks++; if (pops != 5) begin errors++; $display("FAIL flush_pops: got %0d expected 5", pops); end
            end else begin
                checks++; if (in_ready !== 1'b0 || flush_busy !== 1'b1) begin errors++; $display("FAIL flush_busy: ready=%b busy=%b expected 0 1", in_ready, flush_busy); end
                if (out_valid) begin
                    checks++; if (out_data !== DW'(200 + pops)) begin errors++; $display("FAIL flush_data: got %0d expected %0d", out_data, 200 + pops); end
                    pops++;
                end
            end
            tick();
        end
        checks++; if (!seen) begin errors++; $display("FAIL flush_done_timeout: got 0 expected 1"); end
        set_in(0, 1, 32'hBAD, 1, 0);
        checks++; if (flush_busy !== 1'b0 || flush_done !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL flush_reopen: busy=%b done=%b ready=%b expected 0 0 1", flush_busy, flush_done, in_ready); end
        tick();
        drain_all();
    endtask

    task automatic test_flush_empty();
        set_in(0, 0, '0, 0, 1);
        checks++; if (flush_busy !== 1'b0) begin errors++; $display("FAIL empty_idle: got %b expected 0", flush_busy); end
        tick();
        set_in(0, 0, '0, 0, 0);
        checks++; if (flush_busy !== 1'b1 || flush_done !== 1'b0) begin errors++; $display("FAIL empty_c1: busy=%b done=%b expected 1 0", flush_busy, flush_done); end
        tick();
        checks++; if (flush_busy !== 1'b1 || flush_done !== 1'b1 || flushed_count !== '0) begin errors++; $display("FAIL empty_c2: busy=%b done=%b cnt=%0d expected 1 1 0", flush_busy, flush_done, flushed_count); end
        tick();
        checks++; if (flush_busy !== 1'b0 || flush_done !== 1'b0) begin errors++; $display("FAIL empty_c3: busy=%b done=%b expected 0 0", flush_busy, flush_done); end
    endtask

    task automatic test_flush_toggle();
        int idx = -1;
        for (int i = 0; i < 4; i++) begin set_in(0, 1, 400 + i, 0, 0); tick(); end
        set_in(0, 0, '0, 0, 1);
        tick();
        for (int c = 0; c < 30 && idx < 0; c++) begin
            set_in(0, 0, '0, (c % 2) == 0, c == 1);
            if (flush_done) begin
                idx = c;
                checks++; if (flushed_count !== CW'(4)) begin errors++; $display("FAIL toggle_count: got %0d expected 4", flushed_count); end
            end
            tick();
        end
        checks++; if (idx != 7) begin errors++; $display("FAIL toggle_time: done at %0d expected 7", idx); end
        set_in(0, 0, '0, 0, 0);
        checks++; if (flush_busy !== 1'b0) begin errors++; $display("FAIL toggle_retrigger: busy=%b expected 0", flush_busy); end
    endtask

    task automatic test_reset_midflush();
        for (int i = 0; i < 6; i++) begin set_in(0, 1, 300 + i, 0, 0); tick(); end
        set_in(0, 0, '0, 0, 1);
        tick();
        for (int k = 0; k < 2; k++) begin
            set_in(0, 0, '0, 1, 0);
            checks++; if (out_data !== DW'(300 + k)) begin errors++; $display("FAIL mid_pop%0d: got %0d expected %0d", k, out_data, 300 + k); end
            tick();
        end
        set_in(1, 0, '0, 0, 0);
        tick();
        set_in(0, 0, '0, 0, 0);
        checks++; if (level !== '0 || flush_busy !== 1'b0 || flushed_count !== '0) begin errors++; $display("FAIL mid_reset: level=%0d busy=%b cnt=%0d expected 0 0 0", level, flush_busy, flushed_count); end
        for (int c = 0; c < 3; c++) begin
            set_in(0, 0, '0, 0, 0);
            checks++; if (flush_done !== 1'b0) begin errors++; $display("FAIL mid_no_done: got %b expected 0", flush_done); end
            tick();
        end
        set_in(0, 1, 32'h55, 0, 0);
        tick();
        set_in(0, 0, '0, 1, 0);
        checks++; if (out_valid !== 1'b1 || out_data !== 32'h55 || level !== CW'(1)) begin errors++; $display("FAIL mid_after: v=%b d=%0h l=%0d expected 1 55 1", out_valid, out_data, level); end
        tick();
        set_in(0, 0, '0, 0, 0);
        checks++; if (level !== '0) begin errors++; $display("FAIL mid_empty: got %0d expected 0", level); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 800; c++) begin
            set_in($urandom_range(0, 199) == 0, $urandom_range(0, 2) != 0, $urandom,
                   $urandom_range(0, 2) == 0, $urandom_range(0, 24) == 0);
            checks++;
            if (in_ready !== m_in_ready() || out_valid !== m_out_valid() || flush_busy !== (mphase != 0) ||
                flush_done !== (mphase == 2) || level !== CW'(mq.size()) || flushed_count !== CW'(mcount)) begin
                errors++;
                $display("FAIL rand_ctrl c=%0d: rdy=%b v=%b busy=%b done=%b lvl=%0d cnt=%0d expected %b %b %b %b %0d %0d",
                         c, in_ready, out_valid, flush_busy, flush_done, level, flushed_count,
                         m_in_ready(), m_out_valid(), mphase != 0, mphase == 2, mq.size(), mcount);
            end
            if (m_out_valid()) begin
                checks++;
                if (out_data !== mq[0]) begin errors++; $display("FAIL rand_data c=%0d: got %0h expected %0h", c, out_data, mq[0]); end
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_fill_wrap();
        test_flush_basic();
        test_flush_empty();
        test_flush_toggle();
        test_reset_midflush();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
